level_sequencer: RTL and testbench
==================================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 TITLE_FRAMES, 120: frames the level banner (level_one/level_two) is shown before play.
REQ-002 GAP1, 60: frames between successive block releases in level 1.
REQ-003 GAP2, 30: frames between successive block releases in level 2.
REQ-004 Clk  input  1  system clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 frame_clk  input  1  VGA vertical-sync tick, asynchronous to Clk.
REQ-007 start  input  1  start/restart request (key press), level-sensitive.
REQ-008 collide  input  1  any ball-to-block or ball-to-rect hit, valid per Clk.
REQ-009 block_done  input  10  bit i pulses when block i leaves the playfield.
REQ-010 rect_done  input  3  bit k pulses when rect k leaves the playfield.
REQ-011 level_one  output  1  "LEVEL ONE" banner enable.
REQ-012 level_two  output  1  "LEVEL TWO" banner enable.
REQ-013 block_ready  output  10  bit i enables drawing/motion of block i.
REQ-014 rect_ready  output  3  bit k enables drawing/motion of rect k.
REQ-015 game_over  output  1  high in LOSE.
REQ-016 game_won  output  1  high in WIN.

Function
REQ-017 frame_clk SHALL pass a 2-flop synchronizer; a frame tick is one Clk-wide pulse on its synchronized rising edge; tick-to-counter latency 3 Clk.
REQ-018 FSM states SHALL be IDLE, TITLE1, PLAY1, TITLE2, PLAY2, WIN, LOSE; all outputs registered.
REQ-019 IDLE -> TITLE1 when start=1; frame counter and release index cleared on entry to every TITLE and PLAY state.
REQ-020 TITLEn: level_one (n=1) or level_two (n=2) SHALL be 1; after TITLE_FRAMES ticks -> PLAYn; all ready bits 0.
REQ-021 PLAYn: first block (index 0) released on the first tick; thereafter block index j released every GAPn ticks, j = 0..9 in order; release sets block_ready[j] next Clk.
REQ-022 PLAY2 only: rect k released in the same cycle as block 3k+2 (k=0..2).
REQ-023 block_done[i]/rect_done[k] SHALL clear the corresponding ready bit next Clk; done for a bit already 0 ignored.
REQ-024 Level complete = all 10 blocks (and in PLAY2 all 3 rects) released and all ready bits 0; PLAY1 -> TITLE2, PLAY2 -> WIN.
REQ-025 collide=1 in PLAYn -> LOSE next Clk, all ready bits cleared same edge; collide ignored outside PLAYn.
REQ-026 Simultaneous collide and level-complete: LOSE wins.
REQ-027 Simultaneous release and done of different indices both applied in the same cycle.
REQ-028 WIN/LOSE: hold until start=0 then start=1 seen (edge), -> TITLE1; start held high through WIN/LOSE SHALL NOT restart.
REQ-029 Frame counter 8-bit, saturating only via compare-and-clear; release index 4-bit, stops at 10.
REQ-030 level_one and level_two never both 1; game_over and game_won never both 1.

Reset
REQ-031 Reset=0 SHALL immediately force IDLE, all outputs 0, counters 0, synchronizer flops 0, regardless of Clk.
REQ-032 Reset asserted mid-PLAY SHALL drop every ready bit asynchronously; after release, no output changes until start=1.

Verification (TITLE_FRAMES=4, GAP1=3, GAP2=2)
REQ-033 Reset, start=1, 4 ticks -> level_one=1 for 4 ticks, then PLAY1, block_ready=10'b1 after tick 1.
REQ-034 PLAY1, no done pulses -> block_ready bits set at ticks 1,4,7,...,28; after all 10 done pulses -> level_two=1.
REQ-035 PLAY2 -> rect_ready[0] set with block 2 (tick 5), rect_ready[2] with block 8 (tick 17); all done -> game_won=1.
REQ-036 collide=1 with 3 blocks ready in PLAY1 -> next Clk game_over=1, block_ready=0; collide and final done same cycle -> game_over=1.
REQ-037 Reset=0 asserted mid-PLAY2 between Clk edges -> outputs 0 before next edge; start held high from LOSE -> stays LOSE until start toggles.

Source files
------------

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
//
// Game-flow controller for a two-level falling-block game. It shows a level
// banner for a fixed number of video frames, then releases ten blocks one at a
// time at a per-level frame spacing (level 2 also releases three rectangles),
// tracks which objects are still on the playfield, and ends the game in WIN
// when both levels are cleared or LOSE on any collision.
//
// Parameters
//   TITLE_FRAMES  frames the level banner is shown before play
//   GAP1          frames between block releases in level 1
//   GAP2          frames between block releases in level 2
//
// Ports
//   Clk           system clock, all state changes on the rising edge
//   Reset         asynchronous active-low reset
//   frame_clk     vertical-sync tick, asynchronous to Clk
//   start         start/restart request, level-sensitive
//   collide       ball-to-block or ball-to-rect hit, valid per Clk
//   block_done    bit i pulses when block i leaves the playfield
//   rect_done     bit k pulses when rect k leaves the playfield
//   level_one     "LEVEL ONE" banner enable
//   level_two     "LEVEL TWO" banner enable
//   block_ready   bit i enables drawing/motion of block i
//   rect_ready    bit k enables drawing/motion of rect k
//   game_over     high while in LOSE
//   game_won      high while in WIN
//
// All outputs are flops loaded from the next-state decode, so they change on
// the same edge as the state register.
// -----------------------------------------------------------------------------
module level_sequencer #(
    parameter int TITLE_FRAMES = 120,
    parameter int GAP1         = 60,
    parameter int GAP2         = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       collide,
    input  logic [9:0] block_done,
    input  logic [2:0] rect_done,
    output logic       level_one,
    output logic       level_two,
    output logic [9:0] block_ready,
    output logic [2:0] rect_ready,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TITLE1 = 3'd1,
        ST_PLAY1  = 3'd2,
        ST_TITLE2 = 3'd3,
        ST_PLAY2  = 3'd4,
        ST_WIN    = 3'd5,
        ST_LOSE   = 3'd6
    } state_t;

    // Counter compare values: the counter runs 0..N-1, so the terminal
    // value is one less than the frame count.
    localparam logic [7:0] TITLE_LAST = 8'(TITLE_FRAMES - 1);
    localparam logic [7:0] GAP1_LAST  = 8'(GAP1 - 1);
    localparam logic [7:0] GAP2_LAST  = 8'(GAP2 - 1);
    localparam logic [3:0] REL_COUNT  = 4'd10;

    // One-hot enable for the block being released.
    function automatic logic [9:0] block_bit(input logic [3:0] idx);
        block_bit = 10'b00_0000_0001 << idx;
    endfunction

    // Rect k rides along with block 3k+2; other block indices carry no rect.
    function automatic logic [2:0] rect_bit(input logic [3:0] idx);
        case (idx)
            4'd2:    rect_bit = 3'b001;
            4'd5:    rect_bit = 3'b010;
            4'd8:    rect_bit = 3'b100;
            default: rect_bit = 3'b000;
        endcase
    endfunction

    // Registered state
    state_t     state_q,       state_d;
    logic       sync1_q,       sync1_d;
    logic       sync2_q,       sync2_d;
    logic       sync3_q,       sync3_d;
    logic       start_q,       start_d;
    logic [7:0] frame_cnt_q,   frame_cnt_d;
    logic [3:0] rel_idx_q,     rel_idx_d;
    logic [9:0] block_ready_q, block_ready_d;
    logic [2:0] rect_ready_q,  rect_ready_d;
    logic       level_one_q,   level_one_d;
    logic       level_two_q,   level_two_d;
    logic       game_over_q,   game_over_d;
    logic       game_won_q,    game_won_d;

    // Combinational helpers
    logic       tick_s;
    logic       start_rise_s;
    logic       release_s;
    logic       all_released_s;
    logic       board_clear_s;
    logic [7:0] gap_last_s;

    // Next-state, counter, ready-bit and output decode.
    always_comb begin
        // frame_clk crosses into Clk through sync1/sync2; sync3 is the
        // previous synchronized value used to detect the rising edge.
        sync1_d = frame_clk;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        start_d = start;

        tick_s       = sync2_q & ~sync3_q;
        start_rise_s = start & ~start_q;

        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        rel_idx_d     = rel_idx_q;
        block_ready_d = 10'b00_0000_0000;
        rect_ready_d  = 3'b000;
        release_s     = 1'b0;

        gap_last_s     = (state_q == ST_PLAY2) ? GAP2_LAST : GAP1_LAST;
        all_released_s = (rel_idx_q == REL_COUNT);
        board_clear_s  = (block_ready_q == 10'b00_0000_0000) && (rect_ready_q == 3'b000);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_TITLE1;
                    frame_cnt_d = 8'd0;
                    rel_idx_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_TITLE1, ST_TITLE2: begin
                if (tick_s) begin
                    if (frame_cnt_q == TITLE_LAST) begin
                        state_d     = (state_q == ST_TITLE1) ? ST_PLAY1 : ST_PLAY2;
                        frame_cnt_d = 8'd0;
                        rel_idx_d   = 4'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end

            ST_PLAY1, ST_PLAY2: begin
                // Block 0 goes on the very first tick of the level; later
                // blocks wait for the counter to reach the gap value. Once
                // all ten are out the counter and index stop moving.
                if (tick_s && !all_released_s) begin
                    if ((rel_idx_q == 4'd0) || (frame_cnt_q == gap_last_s)) begin
                        release_s   = 1'b1;
                        frame_cnt_d = 8'd0;
                        rel_idx_d   = rel_idx_q + 4'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end

                // Done pulses clear only bits that are set; a release and a
                // done on different indices in the same cycle both land.
                block_ready_d = (block_ready_q & ~block_done)
                              | (release_s ? block_bit(rel_idx_q) : 10'b00_0000_0000);
                rect_ready_d  = (rect_ready_q & ~rect_done)
                              | ((release_s && (state_q == ST_PLAY2)) ? rect_bit(rel_idx_q) : 3'b000);

                // A collision outranks level completion in the same cycle.
                if (collide) begin
                    state_d       = ST_LOSE;
                    block_ready_d = 10'b00_0000_0000;
                    rect_ready_d  = 3'b000;
                end else if (all_released_s && board_clear_s) begin
                    state_d     = (state_q == ST_PLAY1) ? ST_TITLE2 : ST_WIN;
                    frame_cnt_d = 8'd0;
                    rel_idx_d   = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_WIN, ST_LOSE: begin
                // Only a fresh press restarts: holding start from the
                // previous game through the end state does nothing.
                if (start_rise_s) begin
                    state_d     = ST_TITLE1;
                    frame_cnt_d = 8'd0;
                    rel_idx_d   = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                frame_cnt_d = 8'd0;
                rel_idx_d   = 4'd0;
            end
        endcase

        level_one_d = (state_d == ST_TITLE1);
        level_two_d = (state_d == ST_TITLE2);
        game_over_d = (state_d == ST_LOSE);
        game_won_d  = (state_d == ST_WIN);
    end

    // State, synchronizer, counters and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            start_q       <= 1'b0;
            frame_cnt_q   <= 8'd0;
            rel_idx_q     <= 4'd0;
            block_ready_q <= 10'b00_0000_0000;
            rect_ready_q  <= 3'b000;
            level_one_q   <= 1'b0;
            level_two_q   <= 1'b0;
            game_over_q   <= 1'b0;
            game_won_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            start_q       <= start_d;
            frame_cnt_q   <= frame_cnt_d;
            rel_idx_q     <= rel_idx_d;
            block_ready_q <= block_ready_d;
            rect_ready_q  <= rect_ready_d;
            level_one_q   <= level_one_d;
            level_two_q   <= level_two_d;
            game_over_q   <= game_over_d;
            game_won_q    <= game_won_d;
        end
    end

    assign level_one   = level_one_q;
    assign level_two   = level_two_q;
    assign block_ready = block_ready_q;
    assign rect_ready  = rect_ready_q;
    assign game_over   = game_over_q;
    assign game_won    = game_won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_sequencer
//
// Directed bench for level_sequencer with TITLE_FRAMES=4, GAP1=3, GAP2=2.
// A behavioural model counts frame ticks per phase and derives how many blocks
// must be out from the tick count; a compare process checks every output on
// every falling edge. Literal checks at key points pin the model.
// -----------------------------------------------------------------------------
module tb_level_sequencer;

    localparam int TF = 4;
    localparam int G1 = 3;
    localparam int G2 = 2;

    localparam int P_IDLE   = 0;
    localparam int P_TITLE1 = 1;
    localparam int P_PLAY1  = 2;
    localparam int P_TITLE2 = 3;
    localparam int P_PLAY2  = 4;
    localparam int P_WIN    = 5;
    localparam int P_LOSE   = 6;

    logic       Clk        = 1'b0;
    logic       Reset      = 1'b0;
    logic       frame_clk  = 1'b0;
    logic       start      = 1'b0;
    logic       collide    = 1'b0;
    logic [9:0] block_done = 10'b0;
    logic [2:0] rect_done  = 3'b0;
    logic       level_one;
    logic       level_two;
    logic [9:0] block_ready;
    logic [2:0] rect_ready;
    logic       game_over;
    logic       game_won;

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    int       m_phase      = P_IDLE;
    int       m_ticks      = 0;
    int       m_released   = 0;
    bit [9:0] m_blk        = 10'b0;
    bit [2:0] m_rect       = 3'b0;
    bit       m_start_prev = 1'b0;
    bit [2:0] m_hist       = 3'b0;

    level_sequencer #(
        .TITLE_FRAMES(TF),
        .GAP1        (G1),
        .GAP2        (G2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .start      (start),
        .collide    (collide),
        .block_done (block_done),
        .rect_done  (rect_done),
        .level_one  (level_one),
        .level_two  (level_two),
        .block_ready(block_ready),
        .rect_ready (rect_ready),
        .game_over  (game_over),
        .game_won   (game_won)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enter(input int p);
        m_phase    = p;
        m_ticks    = 0;
        m_released = 0;
    endtask

    // Advance the model by one rising edge of Clk.
    task automatic model_step();
        bit       tick;
        bit       complete;
        bit [9:0] nb;
        bit [2:0] nr;
        int       gap;
        int       due;
        if (!Reset) begin
            m_phase      = P_IDLE;
            m_ticks      = 0;
            m_released   = 0;
            m_blk        = 10'b0;
            m_rect       = 3'b0;
            m_start_prev = 1'b0;
            m_hist       = 3'b0;
        end else begin
            // m_hist[0..2] = frame_clk seen 1, 2, 3 edges ago; the tick acts
            // three edges after the rising edge was first sampled.
            tick   = m_hist[1] && !m_hist[2];
            m_hist = {m_hist[1], m_hist[0], frame_clk};
            nb = m_blk & ~block_done;
            nr = m_rect & ~rect_done;
            case (m_phase)
                P_IDLE: if (start) enter(P_TITLE1);
                P_TITLE1, P_TITLE2: begin
                    if (tick) begin
                        m_ticks = m_ticks + 1;
                        if (m_ticks == TF) enter((m_phase == P_TITLE1) ? P_PLAY1 : P_PLAY2);
                    end
                end
                P_PLAY1, P_PLAY2: begin
                    complete = (m_released == 10) && (m_blk == 10'b0) && (m_rect == 3'b0);
                    gap = (m_phase == P_PLAY1) ? G1 : G2;
                    if (tick && m_released < 10) begin
                        m_ticks = m_ticks + 1;
                        due = (m_ticks - 1) / gap + 1;
                        if (due > m_released) begin
                            nb[m_released] = 1'b1;
                            if (m_phase == P_PLAY2 && (m_released % 3) == 2) nr[m_released / 3] = 1'b1;
                            m_released = m_released + 1;
                        end
                    end
                    if (collide) m_phase = P_LOSE;
                    else if (complete) enter((m_phase == P_PLAY1) ? P_TITLE2 : P_WIN);
                end
                P_WIN, P_LOSE: if (start && !m_start_prev) enter(P_TITLE1);
                default: m_phase = P_IDLE;
            endcase
            if (m_phase == P_PLAY1 || m_phase == P_PLAY2) begin
                m_blk  = nb;
                m_rect = nr;
            end else begin
                m_blk  = 10'b0;
                m_rect = 3'b0;
            end
            m_start_prev = start;
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            model_step();
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        logic [16:0] exp_v;
        logic [16:0] act_v;
        forever begin
            @(negedge Clk);
            if (!Reset) exp_v = 17'b0;
            else exp_v = {(m_phase == P_TITLE1) ? 1'b1 : 1'b0,
                          (m_phase == P_TITLE2) ? 1'b1 : 1'b0,
                          m_blk, m_rect,
                          (m_phase == P_LOSE) ? 1'b1 : 1'b0,
                          (m_phase == P_WIN)  ? 1'b1 : 1'b0};
            act_v = {level_one, level_two, block_ready, rect_ready, game_over, game_won};
            chk("scoreboard", 32'(act_v), 32'(exp_v));
        end
    end

    // One frame tick; dmask is pulsed on block_done in the cycle the tick acts.
    task automatic frame_tick(input logic [9:0] dmask);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        frame_clk  = 1'b0;
        block_done = dmask;
        @(negedge Clk);
        block_done = 10'b0;
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick(10'b0);
    endtask

    task automatic pulse_done(input logic [9:0] b, input logic [2:0] r);
        @(negedge Clk);
        block_done = b;
        rect_done  = r;
        @(negedge Clk);
        block_done = 10'b0;
        rect_done  = 3'b0;
    endtask

    task automatic press_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] one_hot;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_block_ready", 32'(block_ready), 32'h0);
        chk("rst_level_one",   32'(level_one),   32'h0);
        chk("rst_game_over",   32'(game_over),   32'h0);
        @(negedge Clk);
        #1 Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("idle_no_start", 32'({level_one, level_two, block_ready, game_won}), 32'h0);

        // Level 1 banner, then releases at ticks 1,4,7,...,28
        press_start();
        chk("title1_banner", 32'(level_one), 32'h1);
        ticks(3);
        chk("title1_still", 32'(level_one), 32'h1);
        ticks(1);
        chk("title1_over", 32'(level_one), 32'h0);
        ticks(1);
        chk("play1_tick1", 32'(block_ready), 32'h001);
        ticks(3);
        chk("play1_tick4", 32'(block_ready), 32'h003);
        ticks(3);
        chk("play1_tick7", 32'(block_ready), 32'h007);
        ticks(21);
        chk("play1_tick28", 32'(block_ready), 32'h3FF);
        for (int i = 0; i < 10; i++) begin
            one_hot = 10'b1;
            one_hot = one_hot << i;
            pulse_done(one_hot, 3'b0);
        end
        @(negedge Clk);
        chk("level_two_on", 32'(level_two), 32'h1);
        chk("level_one_off", 32'(level_one), 32'h0);

        // Level 2: rects ride with blocks 2,5,8; release+done in same cycle
        ticks(4);
        chk("title2_over", 32'(level_two), 32'h0);
        ticks(2);
        frame_tick(10'h001);
        chk("rel_and_done", 32'(block_ready), 32'h002);
        ticks(2);
        chk("play2_tick5_blk", 32'(block_ready), 32'h006);
        chk("play2_tick5_rect", 32'(rect_ready), 32'h1);
        ticks(12);
        chk("play2_tick17_rect", 32'(rect_ready), 32'h7);
        chk("play2_tick17_blk", 32'(block_ready), 32'h1FE);
        ticks(2);
        chk("play2_tick19_blk", 32'(block_ready), 32'h3FE);
        pulse_done(10'h3FE, 3'b111);
        @(negedge Clk);
        chk("game_won", 32'({game_won, game_over}), 32'h2);

        // Restart from WIN, collide with three blocks out, start held high
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        chk("win_restart", 32'(level_one), 32'h1);
        ticks(4);
        ticks(7);
        chk("three_ready", 32'(block_ready), 32'h007);
        @(negedge Clk);
        collide = 1'b1;
        @(negedge Clk);
        collide = 1'b0;
        chk("collide_over", 32'(game_over), 32'h1);
        chk("collide_clear", 32'(block_ready), 32'h0);
        repeat (5) @(negedge Clk);
        chk("lose_hold_start", 32'({game_over, level_one}), 32'h2);
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("lose_restart", 32'({game_over, level_one}), 32'h1);

        // Into level 2, then asynchronous reset between clock edges
        ticks(4);
        ticks(28);
        pulse_done(10'h3FF, 3'b0);
        @(negedge Clk);
        chk("run_c_level_two", 32'(level_two), 32'h1);
        ticks(4);
        ticks(5);
        chk("run_c_blk", 32'(block_ready), 32'h007);
        chk("run_c_rect", 32'(rect_ready), 32'h1);
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_blk", 32'(block_ready), 32'h0);
        chk("async_rst_rest", 32'({level_one, level_two, rect_ready, game_over, game_won}), 32'h0);
        repeat (2) @(negedge Clk);
        #1 Reset = 1'b1;
        ticks(3);
        chk("post_reset_idle", 32'({level_one, level_two, block_ready, rect_ready, game_over, game_won}), 32'h0);

        // Final done and collide in the same cycle: LOSE wins
        press_start();
        chk("run_d_banner", 32'(level_one), 32'h1);
        ticks(4);
        ticks(28);
        pulse_done(10'h1FF, 3'b0);
        chk("run_d_last_block", 32'(block_ready), 32'h200);
        @(negedge Clk);
        block_done = 10'h200;
        collide    = 1'b1;
        @(negedge Clk);
        block_done = 10'b0;
        collide    = 1'b0;
        chk("collide_vs_done", 32'({game_over, game_won, level_two}), 32'h4);
        chk("collide_vs_done_blk", 32'(block_ready), 32'h0);

        repeat (3) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
